// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the single-port memory sequencer:
//   - STATE_W    : width of the sequencer state encoding
//   - NOP_INSN   : RISC-V canonical NOP (addi x0,x0,0), used as the fetch
//                  result after reset or after a timed-out fetch
//   - seq_state_e: sequencer states IDLE / DATA / FETCH
// ---------------------------------------------------------------------------
package mem_seq_pkg;

  localparam int STATE_W = 2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mem_port_sequencer_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for mem_ready during one memory access and
// flags expiry on the TIMEOUT-th wait cycle. Only instantiated by
// mem_port_sequencer when SEQ_TIMEOUT_EN is defined.
// Parameters:
//   TIMEOUT  number of wait cycles allowed (>= 2)
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clear   in   restart the count (asserted on the cycle an access is granted)
//   enable  in   current cycle is a wait cycle (access active, no mem_ready)
//   expire  out  this wait cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // count_q holds the number of wait cycles already completed, so expiry is
  // seen while the TIMEOUT-th wait cycle is in progress.
  assign expire = enable && (count_q == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter, cleared at grant so each access starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// ---------------------------------------------------------------------------
// mem_port_sequencer
// Shares one memory port between instruction fetch and load/store for a
// 5-stage RISC-V pipeline. Within one pipeline step the data access (older
// instruction) is issued first, then the fetch; stall_all freezes every
// pipeline register until both requested accesses are done.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : an access that waits TIMEOUT cycles without mem_ready is
//               abandoned, mem_err pulses, result is NOP (fetch) or 0 (load)
//   undefined : accesses wait indefinitely, mem_err is tied to 0
//
// Parameters:
//   XLEN     data/address width
//   TIMEOUT  max wait cycles for mem_ready (SEQ_TIMEOUT_EN only), >= 2
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request / address for this step
//   dm_req, dm_we, dm_addr,
//   dm_wdata                 load/store request from the MEM stage
//   mem_req, mem_we,
//   mem_addr, mem_wdata      shared memory port request side
//   mem_ready, mem_rdata     memory completion and read data
//   if_rdata, dm_rdata       results, valid when stall_all = 0
//   stall_all                hold all pipeline registers
//   mem_err                  one-cycle pulse on access timeout
// ---------------------------------------------------------------------------
module mem_port_sequencer
  import mem_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] if_rdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            stall_all,
  output logic            mem_err
);

  seq_state_e state_q, state_d;

  logic dm_done_q;
  logic if_done_q;
  logic dm_pending;
  logic if_pending;
  logic grant_dm;
  logic grant_if;
  logic timeout_hit;

  assign dm_pending = dm_req & ~dm_done_q;
  assign if_pending = if_req & ~if_done_q;
  assign stall_all  = dm_pending | if_pending;

  assign mem_req = (state_q != IDLE);

`ifdef SEQ_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  // Clearing on the grant cycle means the count is zero on the first
  // cycle spent in DATA/FETCH.
  assign timer_clear  = grant_dm | grant_if;
  assign timer_enable = (state_q != IDLE) && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timeout_hit)
  );

  // mem_err is registered, so the pulse appears on the cycle after the
  // expiring wait cycle (the cycle the sequencer is back in IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decode. Data wins over fetch because the MEM-stage
  // instruction is older than the one being fetched.
  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_pending) begin
          state_d  = DATA;
          grant_dm = 1'b1;
        end else if (if_pending) begin
          state_d  = FETCH;
          grant_if = 1'b1;
        end
      end
      DATA, FETCH: begin
        if (mem_ready || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request registers, done flags and result capture. The done flags only
  // clear on the advance cycle (IDLE with nothing pending), so an access
  // whose request was withdrawn mid-flight still counts as done until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_done_q <= 1'b0;
      if_done_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= XLEN'(NOP_INSN);
      dm_rdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall_all) begin
            dm_done_q <= 1'b0;
            if_done_q <= 1'b0;
          end else if (grant_dm) begin
            mem_addr  <= dm_addr;
            mem_we    <= dm_we;
            mem_wdata <= dm_wdata;
          end else if (grant_if) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
          end
        end
        DATA: begin
          if (mem_ready) begin
            dm_done_q <= 1'b1;
            mem_we    <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            dm_done_q <= 1'b1;
            mem_we    <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= '0;
            end
          end
        end
        FETCH: begin
          if (mem_ready) begin
            if_done_q <= 1'b1;
            if_rdata  <= mem_rdata;
          end else if (timeout_hit) begin
            if_done_q <= 1'b1;
            if_rdata  <= XLEN'(NOP_INSN);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
